fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
// - Shares the single async-FIFO write port (write-pointer producer) among NUM_REQ requesters in the write domain.
// - Round-robin, burst-granular arbitration: a winner holds the port until last beat, MAX_BURST beats or req drop.
// - Gates w_en with producer full so no requester writes into a full FIFO; muxes the winner's data onto w_data.
// PARAMETERS
// - NUM_REQ    4  number of requesters (2..8)
// - DATA_WIDTH 8  FIFO word width
// - MAX_BURST  4  max beats per grant before forced rotation (1..16)
// PORTS
// - clk     in   1                     write-domain clock, all logic on posedge
// - w_rst   in   1                     asynchronous, active-low reset
// - req     in   NUM_REQ               per-requester write request; held with data until accepted
// - last    in   NUM_REQ               per-requester end-of-burst marker, qualified by accept
// - wdata   in   NUM_REQ*DATA_WIDTH    packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
// - full    in   1                     registered full from the write-pointer producer
// - grant   out  NUM_REQ               registered one-hot grant (0 when idle)
// - accept  out  NUM_REQ               combinational: grant[i] & req[i] & !full (beat taken this cycle)
// - w_en    out  1                     |accept, to producer w_en and FIFO memory write enable
// - w_data  out  DATA_WIDTH            wdata of granted requester; 0 when grant==0
// - src_id  out  $clog2(NUM_REQ)       index of granted requester (0 when idle)
// BEHAVIOUR
// - Reset (w_rst low, async, any state): state=IDLE, grant=0, src_id=0, beat_cnt=0, rr_ptr=NUM_REQ-1 (req 0 wins first);
//   w_en/accept/w_data thus 0 immediately. Reset mid-burst abandons the burst; no partial-burst recovery.
// - FSM states: IDLE, BURST.
// - IDLE: grant=0. If |req: winner = first set req searching (rr_ptr+1) upward mod NUM_REQ;
//   next cycle grant=onehot(winner), src_id=winner, rr_ptr=winner, beat_cnt=0, state=BURST. Else stay.
// - Latency: req rising in IDLE at cycle N -> grant at N+1 -> earliest w_en at N+1. Zero-latency accept while granted.
// - BURST, per cycle, for granted requester g:
//   * accept[g] & (last[g] | beat_cnt==MAX_BURST-1) -> grant=0, state=IDLE next cycle (one idle bubble per burst).
//   * accept[g] otherwise -> beat_cnt+1, stay.
//   * req[g]==0 -> release: grant=0, state=IDLE (abandoned burst, beat_cnt ignored).
//   * req[g]==1 & full -> stall: no accept, beat_cnt holds, grant holds indefinitely.
// - beat_cnt width $clog2(MAX_BURST)+1; never exceeds MAX_BURST-1.
// - Requests of non-granted requesters ignored; last from non-granted ignored; last without accept ignored.
// - Simultaneous full & last: no accept, burst continues until a non-full cycle accepts the last beat.
// - Round-robin fairness: with all req high, grants rotate 0,1,2,...,NUM_REQ-1,0; no requester waits > NUM_REQ bursts.
// - At most one accept bit set in any cycle; w_en never high when full==1.
// CONFIGURATION
// - Macro FIFO_ARB_STATS_EN:
//   * defined: adds output wr_count [NUM_REQ*16] -- per-requester 16-bit accepted-beat counters, +1 on accept[i],
//     wrap 0xFFFF->0, reset to 0 by w_rst; plus output stall_count [16], +1 each cycle grant!=0 & req[g] & full, wraps.
//   * undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset: w_rst low with req=4'b1111 -> grant=0, w_en=0; release, req0 at N -> grant=4'b0001 at N+1.
// - Single burst: req1 data 0xA1,0xA2,0xA3, last on 3rd -> 3 consecutive w_en, w_data 0xA1..0xA3, grant=0 next cycle.
// - Round robin: req=4'b1111, each sends 1-beat last bursts -> src_id sequence 0,1,2,3,0 with one idle cycle between.
// - MAX_BURST cutoff: req2 streams 6 beats no last, req3 pending -> 4 beats, grant moves to req3, req2 resumes later.
// - Full stall: full=1 for 3 cycles mid-burst -> w_en=0, grant/beat_cnt held; beats resume after full=0, none lost.
// - FIFO_ARB_STATS_EN: after above, wr_count[2]=6 (plus any test beats), stall_count=3; undefined build compiles clean.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side bus of the FIFO write-port arbiter.
// master: requesters plus the write-pointer producer's full flag.
// slave:  the arbiter, which returns grant/accept and drives the FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SRC_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            last;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic                          full;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            accept;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         w_data;
  logic [SRC_W-1:0]              src_id;

  modport master (
    output req, last, wdata, full,
    input  grant, accept, w_en, w_data, src_id
  );

  modport slave (
    input  req, last, wdata, full,
    output grant, accept, w_en, w_data, src_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing one async-FIFO write port.
// A winner keeps the port until its last beat, MAX_BURST beats, or until it drops req.
// w_en is gated by the producer's full flag so no beat is ever written into a full FIFO.
// Optional per-requester beat counters and a stall counter when FIFO_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no grant; pick next requester after rr_ptr
// BURST | grant held by src_id; beats counted in beat_cnt
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                   clk,
  input  logic                   w_rst,
  fifo_wr_arbiter_if.slave       bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  wr_count,
  output logic [15:0]            stall_count
`endif
);

  localparam int SRC_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]    src_id_q, src_id_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]    accept;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  g_req;
  logic                  g_last;
  logic                  found;
  logic [SRC_W-1:0]      win;

  // Beat acceptance and write-port data mux for the current grant holder.
  always_comb begin
    accept = grant_q & bus.req & {NUM_REQ{~bus.full}};
    g_req  = bus.req[src_id_q];
    g_last = bus.last[src_id_q];
    w_data = '0;
    if (grant_q != '0) begin
      w_data = bus.wdata[src_id_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.grant  = grant_q;
  assign bus.accept = accept;
  assign bus.w_en   = |accept;
  assign bus.w_data = w_data;
  assign bus.src_id = src_id_q;

  // Next-state logic: round-robin pick in IDLE, burst termination in BURST.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    src_id_d   = src_id_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    found      = 1'b0;
    win        = '0;
    case (state_q)
      IDLE: begin
        for (int i = 1; i <= NUM_REQ; i++) begin
          int cand;
          cand = (int'(rr_ptr_q) + i) % NUM_REQ;
          if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = SRC_W'(cand);
          end
        end
        if (found) begin
          grant_d    = NUM_REQ'(1) << win;
          src_id_d   = win;
          rr_ptr_d   = win;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (!g_req) begin
          // Requester dropped out mid-burst: give the port back.
          grant_d    = '0;
          src_id_d   = '0;
          beat_cnt_d = '0;
          state_d    = IDLE;
        end else if (!bus.full) begin
          if (g_last || beat_cnt_q == BEAT_W'(MAX_BURST - 1)) begin
            grant_d    = '0;
            src_id_d   = '0;
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        grant_d    = '0;
        src_id_d   = '0;
        beat_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // Arbiter state registers; rr_ptr resets to the top so requester 0 wins first.
  always_ff @(posedge clk or negedge w_rst) begin
    if (!w_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      src_id_q   <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= SRC_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      src_id_q   <= src_id_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] wr_count_q, wr_count_d;
  logic [15:0]           stall_count_q, stall_count_d;

  // Wrapping beat counters per requester and a stall counter for the holder.
  always_comb begin
    wr_count_d = wr_count_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_count_d[i*16 +: 16] = wr_count_q[i*16 +: 16] + 16'(accept[i]);
    end
    stall_count_d = stall_count_q;
    if (grant_q != '0 && g_req && bus.full) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge w_rst) begin
    if (!w_rst) begin
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, mid-burst reset, then random traffic
// checked every cycle against a burst-level reference model.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic w_rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] wr_count;
  logic [15:0]      stall_count;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .w_rst (w_rst),
    .bus   (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_count    (wr_count),
    .stall_count (stall_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, beats taken in this burst, last winner.
  int m_owner;
  int m_beats;
  int m_rr;
  int m_wr[NR];
  int m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_rr    = NR - 1;
    m_stall = 0;
    for (int i = 0; i < NR; i++) m_wr[i] = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    if (!w_rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_rr + k) % NR;
        if (bus.req[c]) begin
          m_owner = c;
          m_rr    = c;
          m_beats = 0;
          break;
        end
      end
    end else begin
      if (!bus.req[m_owner]) begin
        m_owner = -1;
      end else if (bus.full) begin
        m_stall++;
      end else begin
        m_wr[m_owner]++;
        m_beats++;
        if (bus.last[m_owner] || m_beats == MB) m_owner = -1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [NR-1:0] e_grant, e_acc;
    logic [DW-1:0] e_data;
    logic [1:0]    e_src;
    e_grant = '0; e_acc = '0; e_data = '0; e_src = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_src  = 2'(m_owner);
      e_data = bus.wdata[m_owner*DW +: DW];
      if (bus.req[m_owner] && !bus.full) e_acc[m_owner] = 1'b1;
    end
    chk({tag, ".grant"},  32'(bus.grant),  32'(e_grant));
    chk({tag, ".accept"}, 32'(bus.accept), 32'(e_acc));
    chk({tag, ".w_en"},   32'(bus.w_en),   32'(|e_acc));
    chk({tag, ".w_data"}, 32'(bus.w_data), 32'(e_data));
    chk({tag, ".src_id"}, 32'(bus.src_id), 32'(e_src));
  endtask

  task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] l,
                       input logic f, input logic [NR*DW-1:0] d);
    @(negedge clk);
    bus.req   = r;
    bus.last  = l;
    bus.full  = f;
    bus.wdata = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
  endtask

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR-1:0]    last;
    logic             full;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]    e_grant;
    logic             e_wen;
    logic [DW-1:0]    e_wdata;
    logic [1:0]       e_src;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [NR-1:0] r, input logic [NR-1:0] l, input logic f,
                     input logic [NR*DW-1:0] d, input logic [NR-1:0] g, input logic we,
                     input logic [DW-1:0] wd, input logic [1:0] s);
    vec_t v;
    v.req = r; v.last = l; v.full = f; v.wdata = d;
    v.e_grant = g; v.e_wen = we; v.e_wdata = wd; v.e_src = s;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] D = 32'h1312_1110;

  initial begin
    logic [NR-1:0] rq;

    // single burst from requester 1
    add(4'b0010, 4'b0000, 0, 32'h0000_A100, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b0010, 4'b0000, 0, 32'h0000_A100, 4'b0010, 1, 8'hA1, 2'd1);
    add(4'b0010, 4'b0000, 0, 32'h0000_A200, 4'b0010, 1, 8'hA2, 2'd1);
    add(4'b0010, 4'b0010, 0, 32'h0000_A300, 4'b0010, 1, 8'hA3, 2'd1);
    add(4'b0000, 4'b0000, 0, D,             4'b0000, 0, 8'h00, 2'd0);
    // round robin with one-beat bursts, starting after requester 1
    add(4'b1111, 4'b1111, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b1111, 4'b1111, 0, D, 4'b0100, 1, 8'h12, 2'd2);
    add(4'b1111, 4'b1111, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b1111, 4'b1111, 0, D, 4'b1000, 1, 8'h13, 2'd3);
    add(4'b1111, 4'b1111, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b1111, 4'b1111, 0, D, 4'b0001, 1, 8'h10, 2'd0);
    add(4'b1111, 4'b1111, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b1111, 4'b1111, 0, D, 4'b0010, 1, 8'h11, 2'd1);
    // full stall mid-burst, then full together with last
    add(4'b0100, 4'b0000, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b0100, 4'b0000, 1, D, 4'b0100, 0, 8'h12, 2'd2);
    add(4'b0100, 4'b0000, 1, D, 4'b0100, 0, 8'h12, 2'd2);
    add(4'b0100, 4'b0000, 1, D, 4'b0100, 0, 8'h12, 2'd2);
    add(4'b0100, 4'b0000, 0, D, 4'b0100, 1, 8'h12, 2'd2);
    add(4'b0100, 4'b0100, 1, D, 4'b0100, 0, 8'h12, 2'd2);
    add(4'b0100, 4'b0100, 0, D, 4'b0100, 1, 8'h12, 2'd2);
    add(4'b0000, 4'b0000, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    // MAX_BURST cutoff with requester 3 waiting
    add(4'b0100, 4'b0000, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b1100, 4'b0000, 0, D, 4'b0100, 1, 8'h12, 2'd2);
    add(4'b1100, 4'b0000, 0, D, 4'b0100, 1, 8'h12, 2'd2);
    add(4'b1100, 4'b0000, 0, D, 4'b0100, 1, 8'h12, 2'd2);
    add(4'b1100, 4'b0000, 0, D, 4'b0100, 1, 8'h12, 2'd2);
    add(4'b1100, 4'b0000, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b1100, 4'b1000, 0, D, 4'b1000, 1, 8'h13, 2'd3);
    add(4'b1100, 4'b0000, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b0100, 4'b0100, 0, D, 4'b0100, 1, 8'h12, 2'd2);
    add(4'b0000, 4'b0000, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    // req drop while stalled releases the grant
    add(4'b0001, 4'b0000, 0, D, 4'b0000, 0, 8'h00, 2'd0);
    add(4'b0001, 4'b0000, 1, D, 4'b0001, 0, 8'h10, 2'd0);
    add(4'b0000, 4'b0000, 0, D, 4'b0001, 0, 8'h10, 2'd0);
    add(4'b0000, 4'b0000, 0, D, 4'b0000, 0, 8'h00, 2'd0);

    // reset held with every requester asking
    model_reset();
    w_rst = 1'b0;
    bus.req = '1; bus.last = '0; bus.full = 1'b0; bus.wdata = D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset.grant", 32'(bus.grant), 32'h0);
      chk("reset.w_en",  32'(bus.w_en),  32'h0);
    end
    @(negedge clk);
    w_rst = 1'b1;
    bus.req = '0;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].last, vecs[i].full, vecs[i].wdata);
      chk($sformatf("vec%0d.grant", i),  32'(bus.grant),  32'(vecs[i].e_grant));
      chk($sformatf("vec%0d.w_en", i),   32'(bus.w_en),   32'(vecs[i].e_wen));
      chk($sformatf("vec%0d.w_data", i), 32'(bus.w_data), 32'(vecs[i].e_wdata));
      chk($sformatf("vec%0d.src_id", i), 32'(bus.src_id), 32'(vecs[i].e_src));
      compare_model($sformatf("vec%0d", i));
      tick();
    end

`ifdef FIFO_ARB_STATS_EN
    chk("stats.wr_count2", 32'(wr_count[2*16 +: 16]), 32'd8);
    chk("stats.stall",     32'(stall_count),          32'd5);
`endif

    // asynchronous reset in the middle of a burst
    drive(4'b1000, 4'b0000, 0, D); tick();
    drive(4'b1000, 4'b0000, 0, D); compare_model("prerst"); tick();
    @(negedge clk);
    w_rst = 1'b0;
    #1;
    model_reset();
    chk("midrst.grant",  32'(bus.grant),  32'h0);
    chk("midrst.w_en",   32'(bus.w_en),   32'h0);
    chk("midrst.w_data", 32'(bus.w_data), 32'h0);
    tick();
    @(negedge clk);
    w_rst = 1'b1;
    bus.req = 4'b1111; bus.last = 4'b1111;
    #1;
    compare_model("rel");
    tick();
    drive(4'b1111, 4'b1111, 0, D);
    chk("rel.first_winner", 32'(bus.grant), 32'h1);
    compare_model("rel2");
    tick();

    // random traffic against the model
    rq = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 3) rq = 4'($urandom);
      drive(rq, 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) == 0),
            32'($urandom));
      compare_model("rand");
      tick();
    end

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NR; i++)
      chk($sformatf("stats.wr_count%0d", i), 32'(wr_count[i*16 +: 16]), 32'(m_wr[i] & 16'hFFFF));
    chk("stats.stall_end", 32'(stall_count), 32'(m_stall & 16'hFFFF));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
